cmd_packetizer: RTL and testbench

//  Parametrised command source for the arm controller interface. Accepts (cmd, x, y) motion commands on a

---
 rtl/cmd_packetizer_if.sv | 34 +++
 rtl/cmd_packetizer.sv | 159 +++++++++++++++
 tb/tb_cmd_packetizer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_packetizer_if.sv
// Bus bundle for cmd_packetizer: command input handshake, serialised word stream and FIFO level.
// The packetizer attaches through the master modport; the command source/word sink uses slave.
interface cmd_packetizer_if #(
    parameter int CMD_W   = 5,
    parameter int COORD_W = 14,
    parameter int WORD_W  = 4,
    parameter int DEPTH   = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // valid/ready: a transfer happens on a rising clk edge where both are high; the source holds
    // payload and valid stable until that edge, and ready never depends combinationally on valid.
    logic               in_valid;
    logic               in_ready;
    logic [CMD_W-1:0]   in_cmd;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_word;
    logic               out_first;
    logic               out_last;
    logic [LVL_W-1:0]   fifo_level;

    modport master (
        input  in_valid, in_cmd, in_x, in_y, out_ready,
        output in_ready, out_valid, out_word, out_first, out_last, fifo_level
    );

    modport slave (
        output in_valid, in_cmd, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_word, out_first, out_last, fifo_level
    );
endinterface

// File: rtl/cmd_packetizer.sv
// Buffers (cmd, x, y) commands in a DEPTH-entry FIFO and streams each as LSW-first WORD_W-bit words.
// Optional feature macro: PKT_CHECKSUM_EN appends an XOR checksum word to every packet.
module cmd_packetizer #(
    parameter int CMD_W   = 5,
    parameter int COORD_W = 14,
    parameter int WORD_W  = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    cmd_packetizer_if.master bus,
    output logic             state_o
);
    localparam int CW = (CMD_W + WORD_W - 1) / WORD_W;
    localparam int XW = (COORD_W + WORD_W - 1) / WORD_W;
    localparam int DW = CW + 2 * XW;
`ifdef PKT_CHECKSUM_EN
    localparam int NW = DW + 1;
`else
    localparam int NW = DW;
`endif
    localparam int IDX_W = $clog2(NW);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef logic [NW-1:0][WORD_W-1:0] pkt_t;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic                 ready_en_q;
    logic                 out_valid_q;
    logic                 out_first_q;
    logic                 out_last_q;
    logic [WORD_W-1:0]    out_word_q;
    pkt_t                 mem_q [DEPTH];

    logic [DW*WORD_W-1:0] data_flat;
    pkt_t                 pkt_in;
    pkt_t                 head;
    pkt_t                 next_head;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Fields are zero-extended to whole words and stacked cmd | x | y from word 0 upward.
    always_comb begin
        data_flat = '0;
        data_flat[CMD_W-1:0] = bus.in_cmd;
        data_flat[CW*WORD_W +: COORD_W] = bus.in_x;
        data_flat[(CW+XW)*WORD_W +: COORD_W] = bus.in_y;
    end

`ifdef PKT_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
    always_comb begin
        csum = '0;
        for (int k = 0; k < DW; k++) begin
            csum = csum ^ data_flat[k*WORD_W +: WORD_W];
        end
    end
    assign pkt_in = pkt_t'({csum, data_flat});
`else
    assign pkt_in = pkt_t'(data_flat);
`endif

    assign rd_ptr_nxt = rd_ptr_q + 1'b1;
    assign head       = mem_q[rd_ptr_q];
    assign next_head  = mem_q[rd_ptr_nxt];
    assign idx_nxt    = idx_q + 1'b1;
    assign full       = (level_q == LVL_W'(DEPTH));
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = out_valid_q && bus.out_ready && out_last_q;

    assign bus.in_ready   = ready_en_q && !full;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = out_word_q;
    assign bus.out_first  = out_first_q;
    assign bus.out_last   = out_last_q;
    assign bus.fifo_level = level_q;
    assign state_o        = (state_q == SEND);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_word_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        state_q     <= SEND;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_word_q  <= head[0];
                        out_first_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            idx_q <= '0;
                            // Only entries already stored may follow without a bubble.
                            if (level_q > LVL_W'(1)) begin
                                out_word_q  <= next_head[0];
                                out_first_q <= 1'b1;
                                out_last_q  <= 1'b0;
                            end else begin
                                state_q     <= IDLE;
                                out_valid_q <= 1'b0;
                                out_word_q  <= '0;
                                out_first_q <= 1'b0;
                                out_last_q  <= 1'b0;
                            end
                        end else begin
                            idx_q       <= idx_nxt;
                            out_word_q  <= head[idx_nxt];
                            out_first_q <= 1'b0;
                            out_last_q  <= (idx_nxt == IDX_W'(NW - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_packetizer.sv
// Directed bench for cmd_packetizer: hand-computed word tables plus a small packing model feeding an
// expected queue of {first, last, word} entries.
module tb_cmd_packetizer;
    localparam int CMD_W   = 5;
    localparam int COORD_W = 14;
    localparam int WORD_W  = 4;
    localparam int DEPTH   = 4;
`ifdef PKT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    localparam int NW      = 11;
`else
    localparam bit CSUM_EN = 1'b0;
    localparam int NW      = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    logic state_dbg;

    cmd_packetizer_if #(.CMD_W(CMD_W), .COORD_W(COORD_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

    cmd_packetizer #(.CMD_W(CMD_W), .COORD_W(COORD_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_pkt(input logic [3:0] t[$], input logic [3:0] cs);
        if (CSUM_EN) t.push_back(cs);
        for (int i = 0; i < t.size(); i++) begin
            exp_q.push_back({1'(i == 0), 1'(i == t.size() - 1), t[i]});
        end
    endtask

    task automatic expect_pkt(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
        logic [3:0]  w[$];
        logic [7:0]  ce;
        logic [15:0] xe;
        logic [15:0] ye;
        logic [3:0]  cs;
        ce = {3'b000, c};
        xe = {2'b00, x};
        ye = {2'b00, y};
        w.push_back(ce[3:0]);
        w.push_back(ce[7:4]);
        for (int k = 0; k < 4; k++) w.push_back(xe[k*4 +: 4]);
        for (int k = 0; k < 4; k++) w.push_back(ye[k*4 +: 4]);
        cs = '0;
        foreach (w[i]) cs = cs ^ w[i];
        load_pkt(w, cs);
    endtask

    task automatic push_cmd(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
        bus.in_valid = 1'b1;
        bus.in_cmd   = c;
        bus.in_x     = x;
        bus.in_y     = y;
        check("push_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_cmd   = $urandom_range(0, 31);
        bus.in_x     = $urandom_range(0, 16383);
        bus.in_y     = $urandom_range(0, 16383);
    endtask

    task automatic drain(input bit toggle, input int max_cycles);
        int n = 0;
        int bubbles = 0;
        bit started = 1'b0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            bus.out_ready = toggle ? n[0] : 1'b1;
            if (bus.out_valid) begin
                started = 1'b1;
                if (bus.out_ready) begin
                    check("word", {bus.out_first, bus.out_last, bus.out_word}, exp_q.pop_front());
                end else begin
                    check("stall_hold", {bus.out_first, bus.out_last, bus.out_word}, exp_q[0]);
                end
            end else if (started) begin
                bubbles++;
            end
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        if (!toggle) check("bubbles", bubbles, 0);
        check("idle_after", bus.out_valid, 0);
        exp_q.delete();
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_word", bus.out_word, 0);
        check("rst_flags", {bus.out_first, bus.out_last}, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        check("rel_in_ready", bus.in_ready, 0);
        step();
        check("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t1[$];
        logic [3:0] t6[$];
        t1 = '{4'h3, 4'h1, 4'hC, 4'h5, 4'hA, 4'h2, 4'h1, 4'h3, 4'hF, 4'h0};
        t6 = '{4'hF, 4'h1, 4'hF, 4'hF, 4'hF, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_cmd   = '0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Single packet, sink always ready, minimum latency.
        bus.out_ready = 1'b1;
        load_pkt(t1, 4'hE);
        push_cmd(5'h13, 14'h2A5C, 14'h0F31);
        check("lat_n_valid", bus.out_valid, 0);
        check("lat_n_level", bus.fifo_level, 1);
        step();
        check("lat_n1_valid", bus.out_valid, 1);
        check("lat_n1_state", state_dbg, 1);
        drain(1'b0, 40);

        // Fill the FIFO while stalled, then stream four packets back to back.
        bus.out_ready = 1'b0;
        expect_pkt(5'h01, 14'h0001, 14'h0002);
        expect_pkt(5'h1F, 14'h3FFF, 14'h1234);
        expect_pkt(5'h0A, 14'h0ABC, 14'h2DEF);
        expect_pkt(5'h15, 14'h1111, 14'h3000);
        push_cmd(5'h01, 14'h0001, 14'h0002);
        push_cmd(5'h1F, 14'h3FFF, 14'h1234);
        push_cmd(5'h0A, 14'h0ABC, 14'h2DEF);
        push_cmd(5'h15, 14'h1111, 14'h3000);
        check("full_level", bus.fifo_level, 4);
        check("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_cmd   = 5'h07;
        step();
        bus.in_valid = 1'b0;
        check("full_reject_level", bus.fifo_level, 4);
        drain(1'b0, 100);

        // Sink toggles ready every cycle.
        load_pkt(t1, 4'hE);
        push_cmd(5'h13, 14'h2A5C, 14'h0F31);
        drain(1'b1, 100);

        // Push coinciding with the last word of a packet at level 2.
        bus.out_ready = 1'b0;
        expect_pkt(5'h02, 14'h0123, 14'h0456);
        expect_pkt(5'h03, 14'h0789, 14'h0ABC);
        expect_pkt(5'h04, 14'h1DEF, 14'h2001);
        push_cmd(5'h02, 14'h0123, 14'h0456);
        push_cmd(5'h03, 14'h0789, 14'h0ABC);
        check("s4_level", bus.fifo_level, 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            check("s4_word", {bus.out_first, bus.out_last, bus.out_word}, exp_q.pop_front());
            if (i == NW - 1) begin
                check("s4_ready", bus.in_ready, 1);
                bus.in_valid = 1'b1;
                bus.in_cmd   = 5'h04;
                bus.in_x     = 14'h1DEF;
                bus.in_y     = 14'h2001;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("s4_level_hold", bus.fifo_level, 2);
        check("s4_next_first", {bus.out_valid, bus.out_first}, 2'b11);
        drain(1'b0, 100);

        // Reset in the middle of a packet with a second entry queued.
        bus.out_ready = 1'b0;
        expect_pkt(5'h05, 14'h1357, 14'h2468);
        push_cmd(5'h05, 14'h1357, 14'h2468);
        push_cmd(5'h06, 14'h0F0F, 14'h3333);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("s5_word", {bus.out_first, bus.out_last, bus.out_word}, exp_q.pop_front());
            step();
        end
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("s5_rst_valid", bus.out_valid, 0);
        check("s5_rst_level", bus.fifo_level, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("s5_post_level", bus.fifo_level, 0);
        check("s5_post_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        expect_pkt(5'h09, 14'h0246, 14'h1001);
        push_cmd(5'h09, 14'h0246, 14'h1001);
        drain(1'b0, 40);

        // Saturated fields and zero padding.
        load_pkt(t6, 4'h2);
        push_cmd(5'h1F, 14'h3FFF, 14'h0000);
        drain(1'b0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
